conv_host_ctrl: RTL

Host-side initiator for the `conv_top` shared-bus protocol. It accepts weight and image words from an upstream valid/ready stream and sequences the 2-bit control code against `conv_top`'s request lines. It drives the tristate `iobus` during loads, reads the convolution sum back when `conv_top` signals valid, and returns the sum on a result stream. It sits between the DMA/host stream logic and `conv_top`, replacing the bench-driven sequencing.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_host_watchdog.sv | 34 +++
 rtl/conv_host_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types for the conv_top host controller: bus control codes, FSM states
// and the result-counter width.
package conv_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_W    = 2'd1,
        CTRL_I    = 2'd2,
        CTRL_RD   = 2'd3
    } ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_I = 3'd2,
        ST_WAIT   = 3'd3,
        ST_READ   = 3'd4,
        ST_RESP   = 3'd5
    } host_state_e;

    localparam int WIN_CNT_W = 16;

endpackage

// File: rtl/conv_host_watchdog.sv
// Counts consecutive cycles with en_i high; expire_o flags the TIMEOUT-th cycle.
// Only instantiated when CONV_HOST_TIMEOUT_EN is defined.
module conv_host_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (en_i && count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/conv_host_ctrl.sv
// Host-side initiator for the conv_top shared bus: loads weights/pixels from a
// valid/ready stream, reads the sum back. Optional WAIT timeout: CONV_HOST_TIMEOUT_EN.
module conv_host_ctrl
    import conv_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int N_INPUT   = 49,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wload,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [BUS_WIDTH-1:0] s_data,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [BUS_WIDTH-1:0] r_data,
    output logic [1:0]           o_ctrl,
    input  logic                 i_wreq,
    input  logic                 i_ireq,
    input  logic                 i_val,
    inout  wire  [BUS_WIDTH-1:0] iobus,
    output logic                 o_wloaded,
    output logic [WIN_CNT_W-1:0] o_win_cnt,
    output logic                 o_timeout,
    output logic [2:0]           o_state
);

    // Handshakes: s_valid && s_ready moves one word, r_valid && r_ready retires
    // one result; valid never depends on ready in either direction.

    localparam int CNT_W = $clog2(N_INPUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_INPUT);

    host_state_e          state_q, state_d;
    ctrl_e                ctrl_q, ctrl_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 r_valid_q, r_valid_d;
    logic [BUS_WIDTH-1:0] r_data_q, r_data_d;
    logic                 wloaded_q, wloaded_d;
    logic [WIN_CNT_W-1:0] win_q, win_d;
    logic                 req;
    logic                 wd_expire;
    logic                 read_go;

    // READ is entered only from an idle bus so codes 1/2 never step straight to 3.
    assign read_go = i_val && (ctrl_q == CTRL_IDLE);

    always_comb begin
        state_d   = state_q;
        ctrl_d    = CTRL_IDLE;
        cnt_d     = cnt_q;
        bus_d     = bus_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        wloaded_d = wloaded_q;
        win_d     = win_q;
        s_ready   = 1'b0;
        req       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_wload) begin
                    state_d   = ST_LOAD_W;
                    cnt_d     = '0;
                    wloaded_d = 1'b0;
                end else if (wloaded_q && s_valid) begin
                    state_d = ST_LOAD_I;
                    cnt_d   = '0;
                end
            end
            ST_LOAD_W, ST_LOAD_I: begin
                req     = (state_q == ST_LOAD_W) ? i_wreq : i_ireq;
                s_ready = req && (cnt_q < FULL_CNT);
                if (s_valid && s_ready) begin
                    ctrl_d = (state_q == ST_LOAD_W) ? CTRL_W : CTRL_I;
                    bus_d  = s_data;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        if (state_q == ST_LOAD_W) begin
                            wloaded_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (read_go) begin
                    state_d = ST_READ;
                    ctrl_d  = CTRL_RD;
                end else if (wd_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                r_data_d  = iobus;
                r_valid_d = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (r_valid_q && r_ready) begin
                    r_valid_d = 1'b0;
                    win_d     = win_q + 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= CTRL_IDLE;
            cnt_q     <= '0;
            bus_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            wloaded_q <= 1'b0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            bus_q     <= bus_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            wloaded_q <= wloaded_d;
            win_q     <= win_d;
        end
    end

`ifdef CONV_HOST_TIMEOUT_EN
    logic timeout_q;

    conv_host_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (state_q == ST_IDLE && i_wload) begin
            timeout_q <= 1'b0;
        end else if (state_q == ST_WAIT && !read_go && wd_expire) begin
            timeout_q <= 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign iobus     = (ctrl_q == CTRL_RD) ? {BUS_WIDTH{1'bz}} : bus_q;
    assign o_ctrl    = ctrl_q;
    assign r_valid   = r_valid_q;
    assign r_data    = r_data_q;
    assign o_wloaded = wloaded_q;
    assign o_win_cnt = win_q;
    assign o_state   = state_q;

endmodule
